// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if - EX-stage to HI/LO sequencer bus.
//   start   : EX instruction is a HI/LO operation this cycle
//   md_op   : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_data : operand A / MTHI-MTLO source
//   rt_data : operand B
//   md_use  : decoded in D - instruction touches HI/LO (incl. MFHI/MFLO)
//   busy    : operation in flight
//   stall   : freeze PC/IF/ID, bubble into EX
//   hi_out  : current HI
//   lo_out  : current LO
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport slave  (input  start, md_op, rs_data, rt_data, md_use,
                    output busy, stall, hi_out, lo_out);
    modport master (output start, md_op, rs_data, rt_data, md_use,
                    input  busy, stall, hi_out, lo_out);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl - multi-cycle multiply/divide sequencer owning the MIPS HI/LO
// registers. Accepts MULT/MULTU/DIV/DIVU (busy for a fixed latency, commit at
// the end) and MTHI/MTLO (written at the accepting edge). Raises stall while
// a HI/LO-touching instruction would race an operation in flight.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-high reset, clears all state
//   bus     : muldiv_ctrl_if.slave (start/md_op/operands/md_use in,
//             busy/stall/hi_out/lo_out out)
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    muldiv_ctrl_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic [2:0]  r_op;

    logic        w_accept, w_done;
    logic        w_sgn, w_neg_a, w_neg_b, w_neg_res;
    logic [31:0] w_mag_a, w_mag_b, w_div_b, w_q, w_r, w_quo, w_rem;
    logic [63:0] w_pmag, w_prod;

    assign w_accept = (r_state == S_IDLE) && bus.start && (bus.md_op <= 3'd3);
    assign w_done   = (r_state == S_BUSY) && (r_cnt == CW'(1));

    // Sign-magnitude datapath: one unsigned multiplier and divider serve both
    // signed and unsigned ops. Going through magnitudes also makes
    // 0x80000000 / -1 fall out naturally (quotient wraps to 0x80000000).
    // op[0]=0 selects the signed flavour, op[1]=1 selects divide.
    always_comb begin
        w_sgn     = ~r_op[0];
        w_neg_a   = w_sgn & r_a[31];
        w_neg_b   = w_sgn & r_b[31];
        w_neg_res = w_neg_a ^ w_neg_b;
        w_mag_a   = w_neg_a ? (32'd0 - r_a) : r_a;
        w_mag_b   = w_neg_b ? (32'd0 - r_b) : r_b;
        w_pmag    = {32'd0, w_mag_a} * {32'd0, w_mag_b};
        w_prod    = w_neg_res ? (64'd0 - w_pmag) : w_pmag;
        // Divisor forced non-zero so the divider never sees 0; the result is
        // discarded for a zero divisor anyway.
        w_div_b   = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
        w_q       = w_mag_a / w_div_b;
        w_r       = w_mag_a % w_div_b;
        w_quo     = w_neg_res ? (32'd0 - w_q) : w_q;
        w_rem     = w_neg_a   ? (32'd0 - w_r) : w_r;
    end

    // State register and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= bus.rs_data;
                r_b   <= bus.rt_data;
                r_op  <= bus.md_op;
                r_cnt <= bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CW'(1);
                if (w_done) begin
                    if (!r_op[1]) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (r_b != 32'd0) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
            end else if (bus.start && bus.md_op == 3'd4) begin
                r_hi <= bus.rs_data;
            end else if (bus.start && bus.md_op == 3'd5) begin
                r_lo <= bus.rs_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_BUSY;
            S_BUSY: if (w_done)   w_next = S_IDLE;
            default:              w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy   = (r_state == S_BUSY);
        // Covers the op still sitting in EX as well as the whole busy window.
        bus.stall  = bus.md_use &
                     ((r_state == S_BUSY) | (bus.start & (bus.md_op <= 3'd3)));
        bus.hi_out = r_hi;
        bus.lo_out = r_lo;
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .i_clk(clk), .i_reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t        tbl[10];
    logic [63:0] sb[$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic u);
        bus.start = s; bus.md_op = op; bus.rs_data = a; bus.rt_data = b; bus.md_use = u;
    endtask

    // Issue one MULT/DIV-class op, check the busy/stall window cycle by cycle,
    // then check the committed HI/LO from the scoreboard.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic u,
                          input logic [31:0] ehi, input logic [31:0] elo);
        logic [63:0] e;
        int n;
        n = op[1] ? DC : MC;
        drive(1'b1, op, a, b, u);
        sb.push_back({ehi, elo});
        @(negedge clk);
        chk({name, " busy c0"}, 32'(bus.busy), 32'd0);
        chk({name, " stall c0"}, 32'(bus.stall), 32'(u));
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'd1);
            chk($sformatf("%s stall c%0d", name, c), 32'(bus.stall), 32'(u));
            tick();
        end
        @(negedge clk);
        chk({name, " busy end"}, 32'(bus.busy), 32'd0);
        chk({name, " stall end"}, 32'(bus.stall), 32'd0);
        e = sb.pop_front();
        chk({name, " hi"}, bus.hi_out, e[63:32]);
        chk({name, " lo"}, bus.lo_out, e[31:0]);
        tick();
    endtask

    initial begin
        logic [63:0] e;
        int n;

        tbl[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1] = '{3'd2, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[2] = '{3'd3, 32'd7,        32'd2,        1'b1, 32'd1,        32'd3};
        tbl[3] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001};
        tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000};
        tbl[5] = '{3'd0, 32'd2,        32'd3,        1'b1, 32'd0,        32'd6};
        tbl[6] = '{3'd0, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'd0};
        tbl[7] = '{3'd2, 32'd7,        32'hFFFFFFFE, 1'b1, 32'd1,        32'hFFFFFFFD};
        tbl[8] = '{3'd1, 32'h00010000, 32'h00010000, 1'b0, 32'd1,        32'd0};
        tbl[9] = '{3'd3, 32'hFFFFFFFF, 32'd10,       1'b1, 32'd5,        32'h19999999};

        // reset state
        drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst stall", 32'(bus.stall), 32'd0);
        chk("rst hi", bus.hi_out, 32'd0);
        chk("rst lo", bus.lo_out, 32'd0);
        tick();

        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].use_, tbl[i].ehi, tbl[i].elo);

        // MTHI / MTLO, then DIV by zero leaves them untouched
        drive(1'b1, 3'd4, 32'h1234, 32'd0, 1'b1);
        @(negedge clk);
        chk("mthi stall", 32'(bus.stall), 32'd0);
        tick();
        drive(1'b1, 3'd5, 32'h5678, 32'd0, 1'b1);
        @(negedge clk);
        chk("mthi hi", bus.hi_out, 32'h1234);
        chk("mthi busy", 32'(bus.busy), 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("mtlo lo", bus.lo_out, 32'h5678);
        tick();
        run_op("div0", 3'd2, 32'd99, 32'd0, 1'b1, 32'h1234, 32'h5678);

        // no-op md_op is ignored
        drive(1'b1, 3'd6, 32'hDEAD, 32'hBEEF, 1'b1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("nop busy", 32'(bus.busy), 32'd0);
        chk("nop hi", bus.hi_out, 32'h1234);
        chk("nop lo", bus.lo_out, 32'h5678);
        tick();

        // start while busy is ignored
        drive(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        sb.push_back({32'hFFFFFFFE, 32'h00000001});
        tick();
        bus.start = 1'b0;
        tick();
        drive(1'b1, 3'd5, 32'hAAAA, 32'd0, 1'b1);
        tick();
        drive(1'b1, 3'd4, 32'hBBBB, 32'd0, 1'b1);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy-start busy", 32'(bus.busy), 32'd1);
        chk("busy-start lo", bus.lo_out, 32'h5678);
        n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        chk("busy-start timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        e = sb.pop_front();
        chk("busy-start hi", bus.hi_out, e[63:32]);
        chk("busy-start lo end", bus.lo_out, e[31:0]);
        tick();

        // reset in cycle 3 of a DIV
        drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b1);
        tick();
        bus.start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst stall", 32'(bus.stall), 32'd0);
        chk("midrst hi", bus.hi_out, 32'd0);
        chk("midrst lo", bus.lo_out, 32'd0);
        tick();
        run_op("post-rst mult", 3'd0, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
